// File: rtl/fetch_sequencer_if.sv
// Fetch handshake and ROM address bundle between the sequencer and its environment.
// The master side drives Start, Instruction and ZERO; the sequencer is the slave.
interface fetch_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [8:0]       Instruction;
    logic             ZERO;
    logic [PC_W-1:0]  PC;
    logic             Run;
    logic             branch_taken;
    logic             Ack;
    logic             Timeout;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        output Start, Instruction, ZERO,
        input  PC, Run, branch_taken, Ack, Timeout, CycleCount
    );

    modport slave (
        input  Start, Instruction, ZERO,
        output PC, Run, branch_taken, Ack, Timeout, CycleCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencing for the 9-bit core: start/ack handshake,
// branch/halt decode, watchdog timeout and saturating run-cycle counter.
//
//   state | meaning
//   IDLE  | after reset, waiting for Start
//   LOAD  | Start held, PC/counter/timeout cleared to start values
//   RUN   | executing one instruction per cycle
//   DONE  | halted or watchdog fired, results held until next Start
module fetch_sequencer #(
    parameter int             PC_W       = 10,
    parameter int             START_ADDR = 0,
    parameter logic [3:0]     BRC_OP     = 4'b0111,
    parameter logic [3:0]     HALT_OP    = 4'b1111,
    parameter int             TIMEOUT    = 1023,
    parameter int             CNT_W      = 16
) (
    input logic                CLK,
    input logic                Reset,
    fetch_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [PC_W-1:0]  PC_START = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cycle_cnt;
    logic             timeout_q;

    logic [3:0]       opcode;
    logic             is_halt;
    logic             is_brc;
    logic             take_branch;
    logic [PC_W-1:0]  offset;
    logic [CNT_W-1:0] cnt_next;

    assign opcode      = bus.Instruction[8:5];
    assign is_halt     = (opcode == HALT_OP);
    assign is_brc      = (opcode == BRC_OP);
    assign take_branch = (state == RUN) && is_brc && bus.ZERO;
    assign offset      = {{(PC_W-5){bus.Instruction[4]}}, bus.Instruction[4:0]};
    assign cnt_next    = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_W'(1);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            pc        <= PC_START;
            cycle_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state     <= LOAD;
                        pc        <= PC_START;
                        cycle_cnt <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                LOAD: begin
                    pc        <= PC_START;
                    cycle_cnt <= '0;
                    timeout_q <= 1'b0;
                    if (!bus.Start) state <= RUN;
                end
                RUN: begin
                    // Restart outranks halt and the watchdog
                    if (bus.Start) begin
                        state     <= LOAD;
                        pc        <= PC_START;
                        cycle_cnt <= '0;
                        timeout_q <= 1'b0;
                    end else begin
                        cycle_cnt <= cnt_next;
                        if (is_halt) begin
                            state <= DONE;
                        end else if (cycle_cnt == CNT_LAST) begin
                            state     <= DONE;
                            timeout_q <= 1'b1;
                        end else if (take_branch) begin
                            pc <= pc + offset;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.Start) begin
                        state     <= LOAD;
                        pc        <= PC_START;
                        cycle_cnt <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PC           = pc;
    assign bus.Run          = (state == RUN);
    assign bus.Ack          = (state == DONE);
    assign bus.Timeout      = timeout_q;
    assign bus.CycleCount   = cycle_cnt;
    assign bus.branch_taken = take_branch;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed programs plus random ROM images,
// each compared against a whole-program trace model.
module tb_fetch_sequencer;

    localparam int         PC_W  = 10;
    localparam int         CNT_W = 16;
    localparam int         TO    = 20;
    localparam int         ROM_N = 1 << PC_W;
    localparam logic [3:0] BRC   = 4'b0111;
    localparam logic [3:0] HALT  = 4'b1111;

    logic CLK = 1'b0;
    logic Reset = 1'b0;

    fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    fetch_sequencer #(
        .PC_W(PC_W), .START_ADDR(0), .BRC_OP(BRC), .HALT_OP(HALT),
        .TIMEOUT(TO), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus)
    );

    always #5 CLK = ~CLK;

    logic [8:0] rom  [0:ROM_N-1];
    logic       zmem [0:ROM_N-1];

    assign bus.Instruction = rom[bus.PC];
    assign bus.ZERO        = zmem[bus.PC];

    int checks = 0;
    int errors = 0;

    int exp_pc[$];
    int exp_bt[$];
    int exp_cnt;
    int exp_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Whole-program trace: addresses fetched, branch flags, final count and timeout.
    task automatic model();
        int pc;
        int cnt;
        int off;
        logic [8:0] ins;
        int br;
        pc = 0;
        cnt = 0;
        exp_pc.delete();
        exp_bt.delete();
        exp_to = 0;
        while (1) begin
            ins = rom[pc];
            br  = (ins[8:5] == BRC && zmem[pc]) ? 1 : 0;
            exp_pc.push_back(pc);
            exp_bt.push_back(br);
            if (cnt < (1 << CNT_W) - 1) cnt++;
            if (ins[8:5] == HALT) break;
            if (cnt == TO) begin
                exp_to = 1;
                break;
            end
            if (br != 0) begin
                off = int'(ins[4:0]);
                if (off >= 16) off -= 32;
                pc = (pc + off + ROM_N) % ROM_N;
            end else begin
                pc = (pc + 1) % ROM_N;
            end
        end
        exp_cnt = cnt;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < ROM_N; a++) begin
            rom[a]  = 9'd0;
            zmem[a] = 1'b0;
        end
    endtask

    // Called on a negedge; drives Start for start_cycles cycles then checks the run.
    task automatic run_prog(input string name, input int start_cycles);
        int i;
        model();
        bus.Start = 1'b1;
        for (int k = 0; k < start_cycles; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                chk({name, "_load_pc"}, 32'(bus.PC), 0);
                chk({name, "_load_ack"}, 32'(bus.Ack), 0);
                chk({name, "_load_run"}, 32'(bus.Run), 0);
                chk({name, "_load_cnt"}, 32'(bus.CycleCount), 0);
                chk({name, "_load_to"}, 32'(bus.Timeout), 0);
            end
        end
        bus.Start = 1'b0;
        @(negedge CLK);
        i = 0;
        while (bus.Run === 1'b1 && i < 200) begin
            if (i < exp_pc.size()) begin
                chk($sformatf("%s_pc%0d", name, i), 32'(bus.PC), 32'(exp_pc[i]));
                chk($sformatf("%s_bt%0d", name, i), 32'(bus.branch_taken), 32'(exp_bt[i]));
            end
            i++;
            @(negedge CLK);
        end
        chk({name, "_run_len"}, 32'(i), 32'(exp_pc.size()));
        chk({name, "_ack"}, 32'(bus.Ack), 1);
        chk({name, "_run_off"}, 32'(bus.Run), 0);
        chk({name, "_bt_off"}, 32'(bus.branch_taken), 0);
        chk({name, "_timeout"}, 32'(bus.Timeout), 32'(exp_to));
        chk({name, "_count"}, 32'(bus.CycleCount), 32'(exp_cnt));
        chk({name, "_pc_hold"}, 32'(bus.PC), 32'(exp_pc[exp_pc.size()-1]));
    endtask

    initial begin
        logic [3:0] op;
        int n;
        bus.Start = 1'b0;
        clear_rom();

        // Reset values
        #12;
        chk("rst_pc", 32'(bus.PC), 0);
        chk("rst_run", 32'(bus.Run), 0);
        chk("rst_ack", 32'(bus.Ack), 0);
        chk("rst_to", 32'(bus.Timeout), 0);
        chk("rst_cnt", 32'(bus.CycleCount), 0);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);

        // Five NOPs then HALT at address 5
        rom[5] = {HALT, 5'd0};
        run_prog("basic", 3);
        chk("basic_cnt6", 32'(bus.CycleCount), 6);

        // Backward branch taken (loops until watchdog), then not taken
        clear_rom();
        rom[4]  = {BRC, 5'b11101};
        zmem[4] = 1'b1;
        rom[5]  = {HALT, 5'd0};
        run_prog("brc_taken", 1);
        zmem[4] = 1'b0;
        run_prog("brc_fall", 1);

        // Wrap in both directions
        clear_rom();
        rom[0]    = {BRC, 5'b11110}; zmem[0]    = 1'b1;
        rom[1022] = {BRC, 5'b00011}; zmem[1022] = 1'b1;
        rom[1]    = {BRC, 5'b11100}; zmem[1]    = 1'b1;
        rom[1021] = {HALT, 5'd0};
        run_prog("wrap", 1);

        // Spin on offset 0 until the watchdog fires
        clear_rom();
        rom[2]  = {BRC, 5'd0};
        zmem[2] = 1'b1;
        run_prog("spin", 1);
        chk("spin_to", 32'(bus.Timeout), 1);
        chk("spin_cnt20", 32'(bus.CycleCount), 20);

        // Asynchronous reset mid-RUN at PC=7
        clear_rom();
        rom[12] = {HALT, 5'd0};
        bus.Start = 1'b1;
        @(negedge CLK);
        bus.Start = 1'b0;
        @(negedge CLK);
        n = 0;
        while (bus.PC !== 10'd7 && n < 20) begin
            n++;
            @(negedge CLK);
        end
        chk("arst_reach7", 32'(bus.PC), 7);
        #2 Reset = 1'b0;
        #1;
        chk("arst_pc", 32'(bus.PC), 0);
        chk("arst_run", 32'(bus.Run), 0);
        chk("arst_ack", 32'(bus.Ack), 0);
        chk("arst_to", 32'(bus.Timeout), 0);
        chk("arst_cnt", 32'(bus.CycleCount), 0);
        @(negedge CLK);
        Reset = 1'b1;
        rom[0]  = {BRC, 5'd3};
        zmem[0] = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_pc", 32'(bus.PC), 0);
        chk("idle_run", 32'(bus.Run), 0);
        chk("idle_bt", 32'(bus.branch_taken), 0);
        chk("idle_ack", 32'(bus.Ack), 0);

        // Restart mid-RUN
        clear_rom();
        rom[15] = {HALT, 5'd0};
        bus.Start = 1'b1;
        @(negedge CLK);
        bus.Start = 1'b0;
        @(negedge CLK);
        repeat (4) @(negedge CLK);
        chk("restart_pre_pc", 32'(bus.PC), 4);
        chk("restart_pre_cnt", 32'(bus.CycleCount), 4);
        run_prog("restart", 1);

        // Restart from DONE with a one-cycle Start pulse
        run_prog("again", 1);

        // Random ROM images
        for (int p = 0; p < 8; p++) begin
            for (int a = 0; a < ROM_N; a++) begin
                n = int'($urandom_range(0, 99));
                if (n < 8)       op = HALT;
                else if (n < 40) op = BRC;
                else begin
                    op = 4'($urandom_range(0, 14));
                    if (op == BRC) op = 4'd0;
                end
                rom[a]  = {op, 5'($urandom)};
                zmem[a] = 1'($urandom_range(0, 1));
            end
            run_prog($sformatf("rand%0d", p), int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the 9-bit single-cycle core.
- Sits between the testbench Start/Ack handshake and the instruction ROM address port.
- Decodes branch and halt from the fetched instruction, evaluates the ALU ZERO flag, and advances, branches or stops the PC.
- Provides a watchdog timeout and a cycle counter for performance reporting.

Parameters:
- PC_W, 10, PC / instruction ROM address width.
- START_ADDR, 0, PC value loaded while Start is held.
- BRC_OP, 4'b0111, opcode (Instruction[8:5]) of the conditional branch.
- HALT_OP, 4'b1111, opcode of the halt instruction.
- TIMEOUT, 1023, RUN cycle count at which the watchdog forces DONE.
- CNT_W, 16, cycle counter width.

Ports:
- CLK, input, 1, rising-edge clock.
- Reset, input, 1, asynchronous, active-low reset.
- Start, input, 1, level request: hold high to load START_ADDR; program runs after it falls.
- Instruction, input, 9, current ROM output at address PC.
- ZERO, input, 1, ALU result == 0 for the current instruction.
- PC, output, PC_W, instruction ROM address.
- Run, output, 1, high while executing; gates register-file and data-memory write enables.
- branch_taken, output, 1, combinational: Run & (Instruction[8:5]==BRC_OP) & ZERO.
- Ack, output, 1, program finished (halt or timeout).
- Timeout, output, 1, finish was caused by the watchdog.
- CycleCount, output, CNT_W, number of RUN cycles in the current/last program.

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- State, PC, Timeout and CycleCount are registered. Run and Ack are decoded from state.

Reset (Reset=0, immediate):
- state=IDLE, PC=START_ADDR, Ack=0, Run=0, Timeout=0, CycleCount=0.
- Asserting reset mid-RUN aborts the program immediately. No partial state survives.

IDLE:
- Start=1 -> LOAD. Otherwise stay.

LOAD:
- PC=START_ADDR, CycleCount=0, Timeout=0, Ack=0.
- Stay while Start=1. Start=0 -> RUN next cycle.
- First RUN cycle fetches START_ADDR.

RUN (Run=1), evaluated each cycle, priority order:
1. Instruction[8:5]==HALT_OP -> DONE. PC holds. CycleCount increments for this cycle.
2. CycleCount == TIMEOUT-1 -> DONE, Timeout=1. PC holds. CycleCount becomes TIMEOUT.
3. branch_taken -> PC = PC + sext(Instruction[4:0]). Offset range is -16..+15, relative to the branch's own address.
4. Otherwise PC = PC + 1.
- PC arithmetic is modulo 2^PC_W; wrap in both directions is silent.
- Offset 0 with ZERO=1 spins on the same address until the watchdog fires.
- Branch with ZERO=0 falls through to PC+1. There is no bubble or stall; each branch costs 1 cycle.
- Start=1 during RUN -> LOAD (restart). This takes priority over halt and timeout.

DONE (Ack=1, Run=0):
- PC, CycleCount and Timeout hold.
- Start=1 -> LOAD. Ack drops the cycle LOAD is entered.

Other rules:
- CycleCount saturates at 2^CNT_W-1. It never wraps.
- Instruction and ZERO are ignored outside RUN.

Test Plan:
- Reset, then Start high 3 cycles then low, ROM = 5 NOPs then HALT at addr 5 -> PC 0,1,2,3,4,5. Ack=1 one cycle after PC=5 is fetched. CycleCount=6, Timeout=0.
- Branch at addr 4 with offset -3 (5'b11101), ZERO=1 -> next PC=1. Same instruction with ZERO=0 -> next PC=5. branch_taken is 1 only in the first case.
- PC_W=10, PC=1022, offset +3, ZERO=1 -> PC=1 (wrap). PC=1, offset -4 -> PC=1021.
- TIMEOUT=20, branch offset 0 at addr 2 with ZERO=1 -> PC stuck at 2, then Ack=1 and Timeout=1. CycleCount=20.
- Reset driven low mid-RUN at PC=7 -> all outputs return to reset values with no clock edge. After release, state IDLE ignores Instruction.
- From DONE, pulse Start for 1 cycle -> LOAD, then RUN from START_ADDR. CycleCount restarts at 0, Ack=0. Start raised mid-RUN -> PC=START_ADDR next cycle.
